spi_ram_slave_burst: RTL

Parametrised SPI slave with an embedded RAM. It is the next-generation SPI wrapper: address and data widths and memory depth are configurable. It adds burst write/read with address auto-increment, an optional auto-increment mode for single transfers, and illegal-command flagging. The block sits behind the board-level SPI pins and keeps the existing 3-bit command framing, MSB first.

---
 rtl/spi_ram_pkg.sv | 28 ++
 rtl/spi_ram_mem.sv | 31 +++
 rtl/spi_ram_slave_burst.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command codes, FSM state encoding and framing constants for the
// SPI RAM slave.
package spi_ram_pkg;

   localparam int CMD_W = 3;

   typedef enum logic [CMD_W-1:0] {
      CMD_WR_ADDR  = 3'b000,
      CMD_WR_DATA  = 3'b001,
      CMD_WR_BURST = 3'b010,
      CMD_RD_BURST = 3'b011,
      CMD_RD_ADDR  = 3'b110,
      CMD_RD_DATA  = 3'b111
   } cmd_e;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_CMD     = 4'd1,
      ST_ADDR    = 4'd2,
      ST_WDATA   = 4'd3,
      ST_RDUMMY  = 4'd4,
      ST_RFETCH  = 4'd5,
      ST_RSHIFT  = 4'd6,
      ST_END     = 4'd7,
      ST_DISCARD = 4'd8
   } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with registered read data. The read register
// holds its value until the next read, so the caller can shift it out
// over several cycles.
module spi_ram_mem #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write has priority; the controller never asserts both in one cycle.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_slave_burst.sv
// SPI slave front end for an embedded RAM: 3-bit command framing, MSB
// first, single and burst reads/writes with address wrap at DEPTH-1.
// o_state exposes the FSM for observation.
module spi_ram_slave_burst
   import spi_ram_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 256,
   parameter int AUTO_INC = 0
) (
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_ss_n,
   input  logic   i_mosi,
   output logic   o_miso,
   output logic   o_busy,
   output logic   o_cmd_err,
   output state_e o_state
);

   localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAXW + 1);

   localparam logic [CNT_W-1:0]  C_LAST  = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0]  A_LAST  = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0]  D_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

   state_e            r_state;
   logic [CMD_W-1:0]  r_cmd;
   logic [CNT_W-1:0]  r_cnt;
   logic [MAXW-2:0]   r_sh;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_baddr;
   logic              r_miso;
   logic              r_cmd_err;

   logic [CMD_W-1:0]  w_cmd_next;
   logic [ADDR_W-1:0] w_addr_in;
   logic [DATA_W-1:0] w_data_in;
   logic              w_burst;
   logic              w_active;
   logic              w_mem_we;
   logic              w_mem_re;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_rdata;
   logic              w_rbit;

   // Reduce an out-of-range address into 0..DEPTH-1 (single subtraction).
   function automatic logic [ADDR_W-1:0] f_mod(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] ax;
      ax = {1'b0, a};
      if (ax >= DEPTH_X) begin
         ax = ax - DEPTH_X;
      end
      return ax[ADDR_W-1:0];
   endfunction

   // Next address with wrap from DEPTH-1 back to 0.
   function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] a);
      return (a == LAST_A) ? '0 : a + 1'b1;
   endfunction

   assign w_cmd_next = {r_cmd[CMD_W-2:0], i_mosi};
   assign w_addr_in  = {r_sh[ADDR_W-2:0], i_mosi};
   assign w_data_in  = {r_sh[DATA_W-2:0], i_mosi};
   assign w_burst    = (r_cmd == CMD_WR_BURST) || (r_cmd == CMD_RD_BURST);
   // A bit is only consumed on an edge where the frame is still open.
   assign w_active   = !i_rst && !i_ss_n;

   // RAM port control: writes land on the edge sampling the word's last bit;
   // reads happen in RFETCH and, for bursts, during the LSB cycle so the next
   // word is ready with no gap.
   always_comb begin
      w_mem_we   = w_active && (r_state == ST_WDATA) && (r_cnt == D_LAST);
      w_mem_re   = w_active && ((r_state == ST_RFETCH) ||
                   ((r_state == ST_RSHIFT) && w_burst && (r_cnt == D_LAST)));
      w_mem_addr = w_burst ? r_baddr : (w_mem_we ? r_wr_addr : r_rd_addr);
   end

   // Select the read-data bit for the current position, MSB first.
   always_comb begin
      w_rbit = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         if (r_cnt == CNT_W'(DATA_W - 1 - i)) begin
            w_rbit = w_rdata[i];
         end
      end
   end

   // Main FSM: command decode, address/data capture, read shifting.
   // ss_n high in any active state closes the frame and drops partial work.
   always_ff @(posedge i_clk) begin
      r_cmd_err <= 1'b0;
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_cmd     <= '0;
         r_cnt     <= '0;
         r_sh      <= '0;
         r_wr_addr <= '0;
         r_rd_addr <= '0;
         r_baddr   <= '0;
         r_miso    <= 1'b0;
      end else if (i_ss_n && (r_state != ST_IDLE)) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_miso  <= 1'b0;
      end else begin
         r_miso <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!i_ss_n) begin
                  r_cmd   <= w_cmd_next;
                  r_cnt   <= CNT_W'(1);
                  r_state <= ST_CMD;
               end
            end
            ST_CMD: begin
               r_cmd <= w_cmd_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == C_LAST) begin
                  r_cnt <= '0;
                  case (w_cmd_next)
                     CMD_WR_ADDR, CMD_RD_ADDR,
                     CMD_WR_BURST, CMD_RD_BURST: r_state <= ST_ADDR;
                     CMD_WR_DATA:                r_state <= ST_WDATA;
                     CMD_RD_DATA:                r_state <= ST_RDUMMY;
                     default: begin
                        r_state   <= ST_DISCARD;
                        r_cmd_err <= 1'b1;
                     end
                  endcase
               end
            end
            ST_ADDR: begin
               r_sh  <= w_addr_in[MAXW-2:0];
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == A_LAST) begin
                  r_cnt <= '0;
                  case (r_cmd)
                     CMD_WR_ADDR: begin
                        r_wr_addr <= f_mod(w_addr_in);
                        r_state   <= ST_END;
                     end
                     CMD_RD_ADDR: begin
                        r_rd_addr <= f_mod(w_addr_in);
                        r_state   <= ST_END;
                     end
                     CMD_WR_BURST: begin
                        r_baddr <= f_mod(w_addr_in);
                        r_state <= ST_WDATA;
                     end
                     default: begin
                        r_baddr <= f_mod(w_addr_in);
                        r_state <= ST_RFETCH;
                     end
                  endcase
               end
            end
            ST_WDATA: begin
               r_sh  <= w_data_in[MAXW-2:0];
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == D_LAST) begin
                  r_cnt <= '0;
                  if (w_burst) begin
                     r_baddr <= f_inc(r_baddr);
                  end else begin
                     r_state <= ST_END;
                     if (AUTO_INC != 0) begin
                        r_wr_addr <= f_inc(r_wr_addr);
                     end
                  end
               end
            end
            ST_RDUMMY: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == D_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_RFETCH;
               end
            end
            ST_RFETCH: begin
               if (w_burst) begin
                  r_baddr <= f_inc(r_baddr);
               end
               r_cnt   <= '0;
               r_state <= ST_RSHIFT;
            end
            ST_RSHIFT: begin
               r_miso <= w_rbit;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == D_LAST) begin
                  r_cnt <= '0;
                  // Bursts stay here: the next word was fetched this cycle.
                  if (w_burst) begin
                     r_baddr <= f_inc(r_baddr);
                  end else begin
                     r_state <= ST_END;
                     if (AUTO_INC != 0) begin
                        r_rd_addr <= f_inc(r_rd_addr);
                     end
                  end
               end
            end
            ST_END, ST_DISCARD: begin
               r_state <= r_state;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   spi_ram_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_mem_we),
      .i_re    (w_mem_re),
      .i_addr  (w_mem_addr),
      .i_wdata (w_data_in),
      .o_rdata (w_rdata)
   );

   assign o_miso    = r_miso;
   assign o_busy    = (r_state != ST_IDLE);
   assign o_cmd_err = r_cmd_err;
   assign o_state   = r_state;

endmodule
